// File: rtl/carfield_addr_guard_pkg.sv
// Shared types and default Carfield register-domain address map for carfield_addr_guard.
package carfield_addr_guard_pkg;

    localparam int unsigned DefaultNumTargets = 4;
    localparam int unsigned DefaultAddrWidth  = 48;
    localparam int unsigned RuleAddrWidth     = 64;
    localparam int unsigned ErrCountWidth     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef struct packed {
        logic [RuleAddrWidth-1:0] base;
        logic [RuleAddrWidth-1:0] size;
        logic                     enable;
    } rule_t;

    // Index 0 is the rightmost entry: L2 port0, L2 port1, safety island, mailbox.
    localparam logic [DefaultNumTargets-1:0][DefaultAddrWidth-1:0] DefaultRuleBase = {
        48'h0000_4000_0000,
        48'h0000_6000_0000,
        48'h0000_7820_0000,
        48'h0000_7800_0000
    };

    localparam logic [DefaultNumTargets-1:0][DefaultAddrWidth-1:0] DefaultRuleSize = {
        48'h0000_0000_1000,
        48'h0000_0080_0000,
        48'h0000_0020_0000,
        48'h0000_0020_0000
    };

    localparam logic [DefaultNumTargets-1:0] DefaultRuleEnable = 4'b1111;

    function automatic logic [ErrCountWidth-1:0] sat_inc(input logic [ErrCountWidth-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/carfield_addr_guard_decode.sv
// Combinational address decoder: rule table + address -> hit flag and lowest matching index.
module carfield_addr_guard_decode
    import carfield_addr_guard_pkg::*;
#(
    parameter int unsigned NumTargets = DefaultNumTargets,
    parameter int unsigned AddrWidth  = DefaultAddrWidth,
    parameter int unsigned IdxWidth   = 2
) (
    input  rule_t [NumTargets-1:0] rules_i,
    input  logic  [AddrWidth-1:0]  addr_i,
    output logic                   hit_o,
    output logic  [IdxWidth-1:0]   idx_o
);

    // One extra bit beyond the rule width keeps base+size from wrapping.
    logic [RuleAddrWidth:0] addr_ext;
    logic [RuleAddrWidth:0] base_ext;
    logic [RuleAddrWidth:0] limit_ext;

    always_comb begin
        addr_ext  = {{(RuleAddrWidth + 1 - AddrWidth){1'b0}}, addr_i};
        base_ext  = '0;
        limit_ext = '0;
        hit_o     = 1'b0;
        idx_o     = '0;
        for (int i = NumTargets - 1; i >= 0; i--) begin
            base_ext  = {1'b0, rules_i[i].base};
            limit_ext = base_ext + {1'b0, rules_i[i].size};
            if (rules_i[i].enable && (addr_ext >= base_ext) && (addr_ext < limit_ext)) begin
                hit_o = 1'b1;
                idx_o = IdxWidth'(i);
            end
        end
        if (addr_i[1:0] != 2'b00) begin
            hit_o = 1'b0;
        end
    end

endmodule

// File: rtl/carfield_addr_guard.sv
// Single-outstanding request router with local error responses for unmapped regions.
// Optional timeout abort enabled by defining CARFIELD_ADDR_GUARD_TIMEOUT_EN.
module carfield_addr_guard
    import carfield_addr_guard_pkg::*;
#(
    parameter int unsigned NumTargets    = DefaultNumTargets,
    parameter int unsigned AddrWidth     = DefaultAddrWidth,
    parameter int unsigned DataWidth     = 32,
    parameter logic [NumTargets-1:0][AddrWidth-1:0] RuleBase   = DefaultRuleBase,
    parameter logic [NumTargets-1:0][AddrWidth-1:0] RuleSize   = DefaultRuleSize,
    parameter logic [NumTargets-1:0]                RuleEnable = DefaultRuleEnable,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic [AddrWidth-1:0]                 req_addr_i,
    input  logic                                 req_write_i,
    input  logic [DataWidth-1:0]                 req_wdata_i,
    input  logic [DataWidth/8-1:0]               req_wstrb_i,
    output logic                                 rsp_valid_o,
    input  logic                                 rsp_ready_i,
    output logic [DataWidth-1:0]                 rsp_rdata_o,
    output logic                                 rsp_error_o,
    output logic [NumTargets-1:0]                tgt_req_valid_o,
    input  logic [NumTargets-1:0]                tgt_req_ready_i,
    output logic [AddrWidth-1:0]                 tgt_addr_o,
    output logic                                 tgt_write_o,
    output logic [DataWidth-1:0]                 tgt_wdata_o,
    output logic [DataWidth/8-1:0]               tgt_wstrb_o,
    input  logic [NumTargets-1:0]                tgt_rsp_valid_i,
    input  logic [NumTargets-1:0][DataWidth-1:0] tgt_rsp_rdata_i,
    input  logic [NumTargets-1:0]                tgt_rsp_error_i,
    output logic                                 err_unmapped_o,
    output logic                                 err_timeout_o,
    output logic [ErrCountWidth-1:0]             err_count_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned IdxWidth  = (NumTargets > 1) ? $clog2(NumTargets) : 1;

    rule_t [NumTargets-1:0] rules;

    for (genvar g = 0; g < NumTargets; g++) begin : gen_rules
        assign rules[g].base   = RuleAddrWidth'(RuleBase[g]);
        assign rules[g].size   = RuleAddrWidth'(RuleSize[g]);
        assign rules[g].enable = RuleEnable[g];
    end

    logic                dec_hit;
    logic [IdxWidth-1:0] dec_idx;

    carfield_addr_guard_decode #(
        .NumTargets (NumTargets),
        .AddrWidth  (AddrWidth),
        .IdxWidth   (IdxWidth)
    ) u_decode (
        .rules_i (rules),
        .addr_i  (req_addr_i),
        .hit_o   (dec_hit),
        .idx_o   (dec_idx)
    );

    state_e                   state_q, state_d;
    logic                     req_ready_q, req_ready_d;
    logic [IdxWidth-1:0]      sel_q, sel_d;
    logic [NumTargets-1:0]    tgt_req_valid_q, tgt_req_valid_d;
    logic [AddrWidth-1:0]     tgt_addr_q, tgt_addr_d;
    logic                     tgt_write_q, tgt_write_d;
    logic [DataWidth-1:0]     tgt_wdata_q, tgt_wdata_d;
    logic [StrbWidth-1:0]     tgt_wstrb_q, tgt_wstrb_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                     rsp_error_q, rsp_error_d;
    logic                     err_unmapped_q, err_unmapped_d;
    logic                     err_timeout_q, err_timeout_d;
    logic [ErrCountWidth-1:0] err_count_q, err_count_d;

    logic                 sel_req_ready;
    logic                 sel_rsp_valid;
    logic [DataWidth-1:0] sel_rsp_rdata;
    logic                 sel_rsp_error;
    logic                 timeout_hit;

    assign sel_req_ready = tgt_req_ready_i[sel_q];
    assign sel_rsp_valid = tgt_rsp_valid_i[sel_q];
    assign sel_rsp_rdata = tgt_rsp_rdata_i[sel_q];
    assign sel_rsp_error = tgt_rsp_error_i[sel_q];

`ifdef CARFIELD_ADDR_GUARD_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TimeoutCycles);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(TimeoutCycles - 1);

    logic [CntWidth-1:0] timeout_cnt_q, timeout_cnt_d;

    // Idle clears the counter, so it starts from zero on every FWD entry.
    always_comb begin
        timeout_cnt_d = timeout_cnt_q;
        if (state_q == IDLE) begin
            timeout_cnt_d = '0;
        end else if ((state_q == FWD) || (state_q == WAIT)) begin
            timeout_cnt_d = timeout_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timeout_cnt_q <= '0;
        end else begin
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign timeout_hit = ((state_q == FWD) || (state_q == WAIT)) && (timeout_cnt_q == CntMax);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        sel_d           = sel_q;
        tgt_req_valid_d = tgt_req_valid_q;
        tgt_addr_d      = tgt_addr_q;
        tgt_write_d     = tgt_write_q;
        tgt_wdata_d     = tgt_wdata_q;
        tgt_wstrb_d     = tgt_wstrb_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_rdata_d     = rsp_rdata_q;
        rsp_error_d     = rsp_error_q;
        err_unmapped_d  = 1'b0;
        err_timeout_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    sel_d       = dec_idx;
                    tgt_addr_d  = req_addr_i;
                    tgt_write_d = req_write_i;
                    tgt_wdata_d = req_wdata_i;
                    tgt_wstrb_d = req_wstrb_i;
                    if (dec_hit) begin
                        state_d                  = FWD;
                        tgt_req_valid_d          = '0;
                        tgt_req_valid_d[dec_idx] = 1'b1;
                    end else begin
                        state_d        = RESP;
                        rsp_valid_d    = 1'b1;
                        rsp_rdata_d    = '0;
                        rsp_error_d    = 1'b1;
                        err_unmapped_d = 1'b1;
                    end
                end
            end
            // A response is only legal once the target has taken the request.
            FWD: begin
                if (sel_req_ready && sel_rsp_valid) begin
                    state_d         = RESP;
                    tgt_req_valid_d = '0;
                    rsp_valid_d     = 1'b1;
                    rsp_rdata_d     = sel_rsp_rdata;
                    rsp_error_d     = sel_rsp_error;
                end else if (timeout_hit) begin
                    state_d         = RESP;
                    tgt_req_valid_d = '0;
                    rsp_valid_d     = 1'b1;
                    rsp_rdata_d     = '0;
                    rsp_error_d     = 1'b1;
                    err_timeout_d   = 1'b1;
                end else if (sel_req_ready) begin
                    state_d         = WAIT;
                    tgt_req_valid_d = '0;
                end
            end
            WAIT: begin
                if (sel_rsp_valid) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = sel_rsp_rdata;
                    rsp_error_d = sel_rsp_error;
                end else if (timeout_hit) begin
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_error_d   = 1'b1;
                    err_timeout_d = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
        err_count_d = (err_unmapped_d || err_timeout_d) ? sat_inc(err_count_q) : err_count_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b0;
            sel_q           <= '0;
            tgt_req_valid_q <= '0;
            tgt_addr_q      <= '0;
            tgt_write_q     <= 1'b0;
            tgt_wdata_q     <= '0;
            tgt_wstrb_q     <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_error_q     <= 1'b0;
            err_unmapped_q  <= 1'b0;
            err_timeout_q   <= 1'b0;
            err_count_q     <= '0;
        end else begin
            state_q         <= state_d;
            req_ready_q     <= req_ready_d;
            sel_q           <= sel_d;
            tgt_req_valid_q <= tgt_req_valid_d;
            tgt_addr_q      <= tgt_addr_d;
            tgt_write_q     <= tgt_write_d;
            tgt_wdata_q     <= tgt_wdata_d;
            tgt_wstrb_q     <= tgt_wstrb_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_error_q     <= rsp_error_d;
            err_unmapped_q  <= err_unmapped_d;
            err_timeout_q   <= err_timeout_d;
            err_count_q     <= err_count_d;
        end
    end

    assign req_ready_o     = req_ready_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_rdata_o     = rsp_rdata_q;
    assign rsp_error_o     = rsp_error_q;
    assign tgt_req_valid_o = tgt_req_valid_q;
    assign tgt_addr_o      = tgt_addr_q;
    assign tgt_write_o     = tgt_write_q;
    assign tgt_wdata_o     = tgt_wdata_q;
    assign tgt_wstrb_o     = tgt_wstrb_q;
    assign err_unmapped_o  = err_unmapped_q;
    assign err_timeout_o   = err_timeout_q;
    assign err_count_o     = err_count_q;

endmodule
